bta_adder: RTL and testbench

BTA_ADDER -- requirements
Module: bta_adder

---
 rtl/bta_adder_pkg.sv | 16 +
 rtl/bta_operand_cond.sv | 30 +++
 rtl/bta_adder.sv | 55 +++++
 tb/tb_bta_adder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/bta_adder_pkg.sv
// Shared constants and operand type for the bit-truncation approximate adder.
package bta_adder_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned NAB_DEF   = 1;

  typedef logic [WIDTH_DEF-1:0] operand_t;

  // One registered result set at the default width.
  typedef struct packed {
    operand_t acc;
    operand_t trunc;
    operand_t rnd;
  } result_t;

endpackage

// File: rtl/bta_operand_cond.sv
// Maps one operand to its truncated form (low NAB bits cleared) and its
// rounded form (truncated plus 2^NAB when bit NAB-1 was set).
module bta_operand_cond
  import bta_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned NAB   = NAB_DEF
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] trunc_c,
  output logic [WIDTH-1:0] rnd_c
);

  localparam int unsigned HI_W = WIDTH - NAB;

  if (NAB == 0) begin : g_exact
    assign trunc_c = x;
    assign rnd_c   = x;
  end else begin : g_approx
    logic [HI_W-1:0] hi;
    logic [HI_W-1:0] hi_rnd;

    assign hi      = x[WIDTH-1:NAB];
    // Rounding increment lands on bit NAB; wraps with the upper field.
    assign hi_rnd  = hi + HI_W'(x[NAB-1]);
    assign trunc_c = {hi, {NAB{1'b0}}};
    assign rnd_c   = {hi_rnd, {NAB{1'b0}}};
  end

endmodule

// File: rtl/bta_adder.sv
// Registered exact, truncated and rounded adders with one-cycle latency.
module bta_adder
  import bta_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned NAB   = NAB_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] c_acc,
  output logic [WIDTH-1:0] c_trunc,
  output logic [WIDTH-1:0] c_rnd
);

  logic [WIDTH-1:0] ta_c, ra_c, tb_c, rb_c;
  logic [WIDTH-1:0] sum_acc_c, sum_trunc_c, sum_rnd_c;

  bta_operand_cond #(.WIDTH(WIDTH), .NAB(NAB)) u_cond_a (
    .x       (a),
    .trunc_c (ta_c),
    .rnd_c   (ra_c)
  );

  bta_operand_cond #(.WIDTH(WIDTH), .NAB(NAB)) u_cond_b (
    .x       (b),
    .trunc_c (tb_c),
    .rnd_c   (rb_c)
  );

  // Carry-out is discarded on all three sums.
  assign sum_acc_c   = a + b;
  assign sum_trunc_c = ta_c + tb_c;
  assign sum_rnd_c   = ra_c + rb_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      c_acc     <= '0;
      c_trunc   <= '0;
      c_rnd     <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        c_acc   <= sum_acc_c;
        c_trunc <= sum_trunc_c;
        c_rnd   <= sum_rnd_c;
      end
    end
  end

endmodule

// File: tb/tb_bta_adder.sv
// Self-checking bench for bta_adder: NAB=1 and NAB=0 instances share stimulus.
module tb_bta_adder;
  import bta_adder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  operand_t    a = '0;
  operand_t    b = '0;

  logic        out_valid1, out_valid0;
  operand_t    c_acc1, c_trunc1, c_rnd1;
  operand_t    c_acc0, c_trunc0, c_rnd0;

  int checks = 0;
  int errors = 0;

  // Reference state per instance (index = NAB).
  logic        exp_valid [2];
  operand_t    exp_acc   [2];
  operand_t    exp_trunc [2];
  operand_t    exp_rnd   [2];

  always #5 clk = ~clk;

  bta_adder #(.WIDTH(32), .NAB(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid1), .c_acc(c_acc1), .c_trunc(c_trunc1), .c_rnd(c_rnd1)
  );

  bta_adder #(.WIDTH(32), .NAB(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid0), .c_acc(c_acc0), .c_trunc(c_trunc0), .c_rnd(c_rnd0)
  );

  // Operand approximation by plain arithmetic: drop value below 2^nab,
  // optionally add 2^nab back when the dropped part is at least half of it.
  function automatic longint unsigned approx(operand_t x, int nab, bit rnd);
    longint unsigned v = 64'(x);
    longint unsigned p = 64'd1 << nab;
    longint unsigned low = v % p;
    v = v - low;
    if (rnd && nab > 0 && low >= p / 2) v = v + p;
    return v;
  endfunction

  task automatic chk(string tag, operand_t obs, operand_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("n1_valid", 32'(out_valid1), 32'(exp_valid[1]));
    chk("n1_acc",   c_acc1,   exp_acc[1]);
    chk("n1_trunc", c_trunc1, exp_trunc[1]);
    chk("n1_rnd",   c_rnd1,   exp_rnd[1]);
    chk("n0_valid", 32'(out_valid0), 32'(exp_valid[0]));
    chk("n0_acc",   c_acc0,   exp_acc[0]);
    chk("n0_trunc", c_trunc0, exp_trunc[0]);
    chk("n0_rnd",   c_rnd0,   exp_rnd[0]);
  endtask

  // Apply one cycle of stimulus, advance the model, then check after the edge.
  task automatic drive(bit v, operand_t x, operand_t y);
    in_valid = v;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      if (!rst) begin
        exp_valid[n] = 1'b0;
        exp_acc[n]   = '0;
        exp_trunc[n] = '0;
        exp_rnd[n]   = '0;
      end else begin
        exp_valid[n] = v;
        if (v) begin
          exp_acc[n]   = 32'(64'(x) + 64'(y));
          exp_trunc[n] = 32'(approx(x, n, 1'b0) + approx(y, n, 1'b0));
          exp_rnd[n]   = 32'(approx(x, n, 1'b1) + approx(y, n, 1'b1));
        end
      end
    end
    check_all();
  endtask

  initial begin
    operand_t h_acc, h_trunc, h_rnd;

    for (int n = 0; n < 2; n++) begin
      exp_valid[n] = 1'b0;
      exp_acc[n]   = '0;
      exp_trunc[n] = '0;
      exp_rnd[n]   = '0;
    end

    // Reset with in_valid high: must be ignored.
    rst = 1'b0;
    drive(1'b1, $urandom, $urandom);
    drive(1'b1, $urandom, $urandom);
    chk("rst_acc_zero", c_acc1, 32'd0);
    rst = 1'b1;

    // Directed NAB=1 vectors with literal expectations.
    drive(1'b1, 32'd3, 32'd5);
    chk("d1_valid", 32'(out_valid1), 32'd1);
    chk("d1_acc",   c_acc1,   32'd8);
    chk("d1_trunc", c_trunc1, 32'd6);
    chk("d1_rnd",   c_rnd1,   32'd10);

    drive(1'b1, 32'h7FFF_FFFF, 32'd1);
    chk("d2_acc",   c_acc1,   32'h8000_0000);
    chk("d2_trunc", c_trunc1, 32'h7FFF_FFFE);
    chk("d2_rnd",   c_rnd1,   32'h8000_0002);

    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("d3_acc",   c_acc1,   32'hFFFF_FFFE);
    chk("d3_trunc", c_trunc1, 32'hFFFF_FFFC);
    chk("d3_rnd",   c_rnd1,   32'h0000_0000);
    chk("d3_lowbit", 32'(c_trunc1[0] | c_rnd1[0]), 32'd0);

    // Random pairs; NAB=0 results must agree with each other as well.
    for (int i = 0; i < 5000; i++) begin
      drive(1'b1, $urandom, $urandom);
      chk("n0_trunc_eq_acc", c_trunc0, c_acc0);
      chk("n0_rnd_eq_acc",   c_rnd0,   c_acc0);
    end

    // Sparse valid pattern exercises hold behaviour.
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    // Four back-to-back operations, then idle with outputs held.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom, $urandom);
    end
    h_acc   = exp_acc[1];
    h_trunc = exp_trunc[1];
    h_rnd   = exp_rnd[1];
    drive(1'b0, $urandom, $urandom);
    drive(1'b0, $urandom, $urandom);
    chk("hold_valid", 32'(out_valid1), 32'd0);
    chk("hold_acc",   c_acc1,   h_acc);
    chk("hold_trunc", c_trunc1, h_trunc);
    chk("hold_rnd",   c_rnd1,   h_rnd);

    // Mid-stream reset, then first result with normal latency.
    drive(1'b1, $urandom, $urandom);
    rst = 1'b0;
    drive(1'b1, $urandom, $urandom);
    chk("mid_rst_valid", 32'(out_valid1), 32'd0);
    chk("mid_rst_rnd",   c_rnd1, 32'd0);
    rst = 1'b1;
    drive(1'b1, 32'd3, 32'd5);
    chk("post_rst_valid", 32'(out_valid1), 32'd1);
    chk("post_rst_rnd",   c_rnd1, 32'd10);
    drive(1'b0, 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
